// File: rtl/dircc_link_buffer.sv
// dircc_link_buffer
// Packet-aware Avalon-ST FIFO sitting on one mesh link between two
// processing nodes. It decouples backpressure between the nodes, carries
// {data, startofpacket, endofpacket, empty} bit-exact and in order, and
// raises a sticky flag when the incoming stream breaks packet framing.
//
// Ports
//   clk_clk           : single clock
//   reset_reset       : asynchronous, active-high reset
//   in_*              : Avalon-ST sink (data/valid/ready/sop/eop/empty)
//   out_*             : Avalon-ST source, show-ahead (head entry always visible)
//   level             : number of beats currently stored (0..DEPTH)
//   frame_error       : sticky input framing violation, cleared only by reset
module dircc_link_buffer #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [EMPTY_W-1:0]       in_empty,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [EMPTY_W-1:0]       out_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + 2 + EMPTY_W;

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] head;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          en_q;
  logic          in_pkt_q, in_pkt_d;
  logic          ferr_q, ferr_d;
  logic          push, pop;

  // level never exceeds DEPTH (a power of 2), so its MSB alone means "full".
  // in_ready depends only on registers: no combinational path from out_ready.
  assign in_ready  = en_q && !level_q[AW];
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Outputs are forced to zero while empty so stale storage never shows
  // (this also gives the all-zero reset values without resetting the RAM).
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;
  assign {out_data, out_startofpacket, out_endofpacket, out_empty} = head;

  assign level       = level_q;
  assign frame_error = ferr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    in_pkt_d = in_pkt_q;
    ferr_d   = ferr_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A sop inside a packet, or a non-sop outside one, are both errors:
    // i.e. the beat is wrong exactly when sop equals in_pkt.
    if (push) begin
      if (in_startofpacket == in_pkt_q) ferr_d = 1'b1;
      in_pkt_d = !in_endofpacket;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      en_q     <= 1'b0;
      in_pkt_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      en_q     <= 1'b1;
      in_pkt_q <= in_pkt_d;
      ferr_q   <= ferr_d;
    end
  end

  // Storage holds data only; validity is tracked by level, so no reset here.
  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_startofpacket, in_endofpacket, in_empty};
  end

endmodule

// File: tb/tb_dircc_link_buffer.sv
module tb_dircc_link_buffer;

  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;
  localparam int DEPTH   = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  typedef logic [DATA_W+EMPTY_W+1:0] beat_t;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              sop;
    logic              eop;
    logic [1:0]        emp;
    logic              ordy;
    int                exp_level;
    logic              exp_irdy;
    logic              exp_fe;
  } vec_t;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_startofpacket = 1'b0;
  logic              in_endofpacket = 1'b0;
  logic [EMPTY_W-1:0] in_empty = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic [EMPTY_W-1:0] out_empty;
  logic [LW-1:0]     level;
  logic              frame_error;

  int total = 0;
  int bad   = 0;
  beat_t sb_q[$];
  vec_t  vecs[20];

  dircc_link_buffer #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_empty(out_empty),
    .level(level),
    .frame_error(frame_error)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected beats are queued when a push handshake is seen and
  // the head of the queue must be what the DUT presents whenever valid.
  always @(negedge clk_clk) begin
    check("sb_level", 64'(level), 64'(sb_q.size()));
    check("sb_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    if (out_valid && sb_q.size() != 0)
      check("sb_head", 64'({out_data, out_startofpacket, out_endofpacket, out_empty}), 64'(sb_q[0]));
    if (out_valid && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    if (in_valid && in_ready)
      sb_q.push_back({in_data, in_startofpacket, in_endofpacket, in_empty});
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic sop,
                       input logic eop, input logic [1:0] emp, input logic ordy);
    in_valid         = v;
    in_data          = d;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_empty         = emp;
    out_ready        = ordy;
  endtask

  // Assert reset mid-cycle, check outputs immediately, release mid-cycle,
  // then expect in_ready one edge later.
  task automatic do_reset();
    @(posedge clk_clk);
    #3;
    reset_reset = 1'b1;
    sb_q.delete();
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sop", 64'(out_startofpacket), 64'(0));
    check("rst_out_eop", 64'(out_endofpacket), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_empty", 64'(out_empty), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_frame_error", 64'(frame_error), 64'(0));
    @(posedge clk_clk);
    #3;
    reset_reset = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_level", 64'(level), 64'(0));
  endtask

  function automatic vec_t mk(input logic v, input logic [DATA_W-1:0] d, input logic sop,
                              input logic eop, input logic [1:0] emp, input logic ordy,
                              input int lvl, input logic irdy, input logic fe);
    vec_t r;
    r.v = v; r.d = d; r.sop = sop; r.eop = eop; r.emp = emp; r.ordy = ordy;
    r.exp_level = lvl; r.exp_irdy = irdy; r.exp_fe = fe;
    return r;
  endfunction

  initial begin
    // Single-beat packet, then fill to full, hold off a 9th beat, drain.
    vecs[0] = mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 2'd2, 1'b1, 1, 1'b1, 1'b0);
    vecs[1] = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++)
      vecs[k+1] = mk(1'b1, 32'(k), k == 1, k == 8, 2'(k % 4), 1'b0, k, k < 8, 1'b0);
    vecs[10] = mk(1'b1, 32'h9, 1'b1, 1'b1, 2'd1, 1'b0, 8, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 32'h9, 1'b1, 1'b1, 2'd1, 1'b1, 7, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 32'h9, 1'b1, 1'b1, 2'd1, 1'b1, 7, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      vecs[13+k] = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 6 - k, 1'b1, 1'b0);

    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].sop, vecs[i].eop, vecs[i].emp, vecs[i].ordy);
      tick();
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_irdy));
      check($sformatf("vec%0d_frame_error", i), 64'(frame_error), 64'(vecs[i].exp_fe));
    end

    // Concurrency and wrap: hold level at 3 with push+pop for 20 cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom, k == 0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
      tick();
      check("wrap_fill_level", 64'(level), 64'(k + 1));
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, $urandom, 1'b0, k == 19, 2'($urandom_range(0, 3)), 1'b1);
      tick();
      check("wrap_level", 64'(level), 64'(3));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (3) tick();
    check("wrap_drained", 64'(level), 64'(0));
    check("wrap_frame_error", 64'(frame_error), 64'(0));

    // Framing: sop followed by sop.
    do_reset();
    drive(1'b1, 32'hA0, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    check("dup_sop_first", 64'(frame_error), 64'(0));
    drive(1'b1, 32'hA1, 1'b1, 1'b0, 2'd3, 1'b0);
    tick();
    check("dup_sop_err", 64'(frame_error), 64'(1));
    check("dup_sop_level", 64'(level), 64'(2));
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (2) tick();
    check("dup_sop_drained", 64'(level), 64'(0));

    // Framing: non-sop first beat after reset; error stays sticky.
    do_reset();
    drive(1'b1, 32'hB0, 1'b0, 1'b1, 2'd1, 1'b1);
    tick();
    check("nosop_err", 64'(frame_error), 64'(1));
    drive(1'b1, 32'hB1, 1'b1, 1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b1, 32'hB2, 1'b0, 1'b1, 2'd2, 1'b1);
    tick();
    check("nosop_sticky", 64'(frame_error), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (2) tick();
    check("nosop_drained", 64'(level), 64'(0));

    // Reset mid-packet, then a clean packet.
    do_reset();
    drive(1'b1, 32'hC0, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    drive(1'b1, 32'hC1, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    drive(1'b1, 32'hC2, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    check("midpkt_level", 64'(level), 64'(3));
    do_reset();
    drive(1'b1, 32'hD0, 1'b1, 1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b1, 32'hD1, 1'b0, 1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b1, 32'hD2, 1'b0, 1'b1, 2'd3, 1'b1);
    tick();
    check("after_rst_frame_error", 64'(frame_error), 64'(0));
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (2) tick();
    check("after_rst_drained", 64'(level), 64'(0));

    check("sb_all_consumed", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dircc_link_buffer.md
# dircc_link_buffer

Packet-aware Avalon-ST FIFO placed on each mesh link between two `dircc_processing_gals_node` instances. It consumes one node's `output_<dir>_*` stream and feeds the neighbour's `input_<opposite dir>_*` stream. It decouples backpressure between nodes, preserves 32-bit packet framing (startofpacket, endofpacket, empty), and flags framing violations on its input side.

## Interface
- `DATA_W`, default 32: beat data width.
- `EMPTY_W`, default 2: width of the empty field.
- `DEPTH`, default 8: FIFO depth in beats. Must be a power of 2, ≥2.
- `clk_clk` in 1: single clock, all logic.
- `reset_reset` in 1: reset, asynchronous, active-high.
- `in_data` in DATA_W: sink beat data.
- `in_valid` in 1: sink beat valid.
- `in_ready` out 1: sink can accept a beat.
- `in_startofpacket` in 1: first beat of packet.
- `in_endofpacket` in 1: last beat of packet.
- `in_empty` in EMPTY_W: unused byte lanes, meaningful on the endofpacket beat.
- `out_data` out DATA_W: source beat data.
- `out_valid` out 1: source beat valid.
- `out_ready` in 1: downstream accepts a beat.
- `out_startofpacket`, `out_endofpacket` out 1: source framing.
- `out_empty` out EMPTY_W: source empty field.
- `level` out $clog2(DEPTH)+1: beats currently stored.
- `frame_error` out 1: sticky input framing violation.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Storage is DEPTH entries of {data, sop, eop, empty}. Write and read pointers increment modulo DEPTH and wrap silently.
- `in_ready` = enable flag && (`level` < DEPTH).
  - The enable flag is cleared by reset and set on the first clock edge after reset deasserts.
  - `in_ready` has no combinational path from `out_ready`.
- When full, a pop in the same cycle does not permit a push. `in_ready` rises the cycle after the pop.
- The output is show-ahead. `out_valid` = (`level` != 0). `out_*` present the entry at the read pointer.
- `out_*` hold stable while `out_valid && !out_ready`.
- Simultaneous push and pop with 0 < `level` < DEPTH leaves `level` unchanged. Otherwise `level` changes by +1 per push and −1 per pop.
- A pop with `level` = 0 cannot occur because `out_valid` = 0.
- All fields, including `in_empty` on non-eop beats, are stored and reproduced bit-exact. There is no reordering and no dropping.
- The framing tracker uses an `in_pkt` flag and updates only on pushes:
  - sop pushed while `in_pkt` = 1 sets `frame_error`.
  - A non-sop beat pushed while `in_pkt` = 0 sets `frame_error`.
  - After any push, `in_pkt` = !eop of that beat. A sop+eop beat is a legal single-beat packet.
  - Offending beats are still stored and forwarded unchanged.
  - `frame_error` stays set until reset.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_startofpacket` 0, `out_endofpacket` 0, `out_data` 0, `out_empty` 0, `level` 0, `frame_error` 0, `in_pkt` 0, pointers 0.
- Latency: a beat pushed at edge N is visible on `out_*` with `out_valid` = 1 in the cycle after edge N. This assumes an empty FIFO, or that the beat has reached the head.
- Throughput is 1 beat/cycle sustained with `out_ready` held high, including across pointer wrap.
- `level` and `frame_error` are registered and update at the edge of the causing push or pop.
- Reset asserted mid-packet or mid-stream:
  - Takes effect immediately and asynchronously. All contents are discarded and all outputs return to reset values.
  - After deassertion, the first accepted beat must be sop, otherwise `frame_error` sets.

## Test plan
- Reset: assert `reset_reset` mid-clock → all outputs at reset values immediately. After deassert, `in_ready` = 1 one edge later and `level` = 0.
- Single-beat packet: push data 0xDEADBEEF, sop = eop = 1, empty = 2, with `out_ready` = 1 → next cycle `out_*` match, `level` = 1, then 0 after the pop. `frame_error` = 0.
- Fill and drain with DEPTH = 8:
  - `out_ready` = 0, push 8 beats 0x1..0x8 → `in_ready` = 0 after the 8th and `level` = 8. A 9th beat presented is held off.
  - Raise `out_ready` → beats drain 0x1..0x8 in order. `in_ready` = 1 the cycle after the first pop.
- Concurrency and wrap: at `level` = 3, push and pop each cycle for 20 cycles → `level` stays 3 and the output sequence equals the input sequence across two pointer wraps.
- Framing errors:
  - Push sop, then sop again → `frame_error` = 1, and both beats are still forwarded.
  - After reset, push a non-sop beat → `frame_error` = 1. It remains 1 through subsequent legal packets.
- Reset mid-packet: push sop plus 2 body beats, assert reset → `level` = 0 and `out_valid` = 0. A new sop..eop packet after reset passes with `frame_error` = 0.
